stack_op_sequencer: RTL and testbench

- Multicycle controller sitting directly upstream of the 32x8 operand stack.
- Accepts one stack-machine operation per start pulse: ADD, SUB, AND, NOT, PUSHI, POP, DUP.
- Drives the stack's push/pop/tos strobes, consumes its dout, computes the result, and pushes it back.
- Tracks stack occupancy and refuses operations that would underflow or overflow.

---
 rtl/stack_seq_pkg.sv | 32 +++
 rtl/stack_seq_alu.sv | 38 +++
 rtl/stack_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - shared opcode/state types and defaults for the stack operation sequencer
package stack_seq_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_NOT   = 3'b011,
        OP_PUSHI = 3'b100,
        OP_POP   = 3'b101,
        OP_DUP   = 3'b110,
        OP_ILL   = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_B,
        S_TOS,
        S_GET_B,
        S_GET_A,
        S_PUSH,
        S_DONE
    } state_e;

    function automatic logic is_binary(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// rtl/stack_seq_alu.sv - combinational ALU; a is the deeper operand, carry is borrow for SUB
module stack_seq_alu
    import stack_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  opcode_e       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          carry
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res   = b;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[DW-1:0];
                carry = sum[DW];
            end
            OP_SUB: begin
                res   = diff[DW-1:0];
                carry = diff[DW];
            end
            OP_AND:  res = a & b;
            OP_NOT:  res = ~b;
            default: res = b;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - multicycle stack-machine controller driving a DEPTH x DW operand stack
// Optional Z/C flag outputs under macro STACK_SEQ_FLAGS_EN.
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               opcode,
    input  logic [DW-1:0]            imm,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [DW-1:0]            result,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic                     stk_tos,
`ifdef STACK_SEQ_FLAGS_EN
    output logic                     flag_z,
    output logic                     flag_c,
`endif
    output logic [DW-1:0]            stk_din,
    input  logic [DW-1:0]            stk_dout
);

    localparam int DPW = $clog2(DEPTH) + 1;
    localparam logic [DPW-1:0] FULL = DPW'(DEPTH);

    state_e          state_q, state_d;
    opcode_e         op_q, op_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   result_q, result_d;
    logic            err_q, err_d;
    logic [DPW-1:0]  depth_q;
    logic            illegal;
    logic            wr_flags;
    logic [DW-1:0]   alu_b, alu_res;
    logic            alu_carry;

    // b comes straight off the stack in GET_B (NOT), from the capture register in GET_A
    assign alu_b = (state_q == S_GET_B) ? stk_dout : b_q;

    stack_seq_alu #(.DW(DW)) u_alu (
        .op    (op_q),
        .a     (stk_dout),
        .b     (alu_b),
        .res   (alu_res),
        .carry (alu_carry)
    );

    always_comb begin
        case (opcode_e'(opcode))
            OP_ADD, OP_SUB, OP_AND: illegal = (depth_q < DPW'(2));
            OP_NOT, OP_POP:         illegal = (depth_q == '0);
            OP_DUP:                 illegal = (depth_q == '0) || (depth_q == FULL);
            OP_PUSHI:               illegal = (depth_q == FULL);
            default:                illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        wr_flags = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = opcode_e'(opcode);
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d = 1'b0;
                        case (opcode_e'(opcode))
                            OP_PUSHI: begin
                                result_d = imm;
                                state_d  = S_PUSH;
                            end
                            OP_DUP:  state_d = S_TOS;
                            default: state_d = S_POP_B;
                        endcase
                    end
                end
            end
            S_POP_B, S_TOS: state_d = S_GET_B;
            S_GET_B: begin
                b_d = stk_dout;
                if (is_binary(op_q)) begin
                    state_d = S_GET_A;
                end else if (op_q == OP_NOT) begin
                    result_d = alu_res;
                    wr_flags = 1'b1;
                    state_d  = S_PUSH;
                end else if (op_q == OP_DUP) begin
                    result_d = stk_dout;
                    state_d  = S_PUSH;
                end else begin
                    result_d = stk_dout;
                    state_d  = S_DONE;
                end
            end
            S_GET_A: begin
                result_d = alu_res;
                wr_flags = 1'b1;
                state_d  = S_PUSH;
            end
            S_PUSH:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            depth_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            if (stk_push)
                depth_q <= depth_q + DPW'(1);
            else if (stk_pop)
                depth_q <= depth_q - DPW'(1);
        end
    end

`ifdef STACK_SEQ_FLAGS_EN
    logic flag_z_q, flag_c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (wr_flags) begin
            flag_z_q <= (result_d == '0);
            flag_c_q <= alu_carry;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic unused_flags;
    assign unused_flags = alu_carry ^ wr_flags;
`endif

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign result   = result_q;
    assign depth    = depth_q;
    assign stk_push = (state_q == S_PUSH);
    assign stk_pop  = (state_q == S_POP_B) || ((state_q == S_GET_B) && is_binary(op_q));
    assign stk_tos  = (state_q == S_TOS);
    assign stk_din  = result_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - randomized self-checking bench with an operation-level stack model
module tb_stack_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [7:0] imm = 8'd0;
    logic       busy, done, err;
    logic [7:0] result;
    logic [5:0] depth;
    logic       stk_push, stk_pop, stk_tos;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
`ifdef STACK_SEQ_FLAGS_EN
    logic       flag_z, flag_c;
`endif

    stack_op_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .imm      (imm),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .depth    (depth),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
`ifdef STACK_SEQ_FLAGS_EN
        .flag_z   (flag_z),
        .flag_c   (flag_c),
`endif
        .stk_din  (stk_din),
        .stk_dout (stk_dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Operand stack emulation: dout registered on pop/tos strobe edges
    logic [7:0] mem[$];
    int push_cnt = 0, pop_cnt = 0, tos_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.delete();
            stk_dout <= 8'd0;
        end else begin
            if (stk_pop) begin
                if (mem.size() > 0) begin
                    stk_dout <= mem[$];
                    void'(mem.pop_back());
                end
                pop_cnt++;
            end
            if (stk_tos) begin
                if (mem.size() > 0) stk_dout <= mem[$];
                tos_cnt++;
            end
            if (stk_push) begin
                mem.push_back(stk_din);
                push_cnt++;
            end
        end
    end

    bit in_op = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("one_strobe", 32'((int'(stk_push) + int'(stk_pop) + int'(stk_tos)) <= 1), 32'd1);
            chk("depth_vs_stack", 32'(depth), 32'(mem.size()));
            if (!in_op) chk("idle_busy", 32'(busy), 32'd0);
        end
    end

    // Operation-level reference model
    int ref_stk[$];
    int m_res = 0;
    bit m_err = 1'b0;
    bit m_z = 1'b0, m_c = 1'b0;
    int last_lat;

    task automatic model_reset();
        ref_stk.delete();
        m_res = 0;
        m_err = 1'b0;
        m_z   = 1'b0;
        m_c   = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge
    task automatic do_op(input logic [2:0] op, input logic [7:0] im, input bit start_in_done);
        int n, lat, npop, npush, ntos, a, b, r, cyc, p0, q0, t0;
        bit ill;
        n = ref_stk.size();
        ill = (op == 3'd7) || (op <= 3'd2 && n < 2) || ((op == 3'd3 || op == 3'd5) && n < 1) ||
              (op == 3'd6 && (n == 0 || n == 32)) || (op == 3'd4 && n == 32);
        npop = 0; npush = 0; ntos = 0; r = m_res; lat = 1;
        if (!ill) begin
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    b = ref_stk.pop_back();
                    a = ref_stk.pop_back();
                    if (op == 3'd0)      begin r = (a + b) & 255; m_c = (a + b) > 255; end
                    else if (op == 3'd1) begin r = (a - b) & 255; m_c = a < b; end
                    else                 begin r = a & b;         m_c = 1'b0; end
                    m_z = (r == 0);
                    ref_stk.push_back(r);
                    lat = 5; npop = 2; npush = 1;
                end
                3'd3: begin
                    b = ref_stk.pop_back();
                    r = (~b) & 255;
                    m_c = 1'b0; m_z = (r == 0);
                    ref_stk.push_back(r);
                    lat = 4; npop = 1; npush = 1;
                end
                3'd4: begin
                    r = int'(im);
                    ref_stk.push_back(r);
                    lat = 2; npush = 1;
                end
                3'd5: begin
                    r = ref_stk.pop_back();
                    lat = 3; npop = 1;
                end
                default: begin
                    r = ref_stk[$];
                    ref_stk.push_back(r);
                    lat = 4; ntos = 1; npush = 1;
                end
            endcase
        end
        m_res = r;
        m_err = ill;
        p0 = push_cnt; q0 = pop_cnt; t0 = tos_cnt;

        start = 1'b1; opcode = op; imm = im;
        @(posedge clk);
        in_op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            chk("busy_mid_op", 32'(busy), 32'd1);
            @(negedge clk);
            cyc++;
        end
        last_lat = cyc;
        chk("latency", 32'(cyc), 32'(lat));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("err", 32'(err), 32'(m_err));
        chk("result", 32'(result), 32'(m_res));
        chk("depth", 32'(depth), 32'(ref_stk.size()));
        chk("push_count", 32'(push_cnt - p0), 32'(npush));
        chk("pop_count", 32'(pop_cnt - q0), 32'(npop));
        chk("tos_count", 32'(tos_cnt - t0), 32'(ntos));
        chk("stack_size", 32'(mem.size()), 32'(ref_stk.size()));
        if (ref_stk.size() > 0 && mem.size() > 0) chk("stack_top", 32'(mem[$]), 32'(ref_stk[$]));
`ifdef STACK_SEQ_FLAGS_EN
        chk("flag_z", 32'(flag_z), 32'(m_z));
        chk("flag_c", 32'(flag_c), 32'(m_c));
`endif
        in_op = 1'b0;
        if (start_in_done) begin
            start = 1'b1; opcode = 3'($urandom_range(0, 7)); imm = 8'($urandom);
            p0 = push_cnt; q0 = pop_cnt;
            @(negedge clk);
            start = 1'b0;
            chk("ignored_start_busy", 32'(busy), 32'd0);
            chk("ignored_start_strobes", 32'((push_cnt - p0) + (pop_cnt - q0)), 32'd0);
        end else begin
            @(negedge clk);
        end
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_strobes", 32'({stk_push, stk_pop, stk_tos}), 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        do_op(3'd4, 8'd5, 1'b0);
        do_op(3'd4, 8'd3, 1'b0);
        do_op(3'd0, 8'd0, 1'b0);
        chk("lit_add_result", 32'(result), 32'd8);
        chk("lit_add_depth", 32'(depth), 32'd1);
        chk("lit_add_latency", 32'(last_lat), 32'd5);
        do_op(3'd5, 8'd0, 1'b0);

        do_op(3'd4, 8'd3, 1'b0);
        do_op(3'd4, 8'd5, 1'b0);
        do_op(3'd1, 8'd0, 1'b0);
        chk("lit_sub_result", 32'(result), 32'hFE);
`ifdef STACK_SEQ_FLAGS_EN
        chk("lit_sub_borrow", 32'(flag_c), 32'd1);
`endif
        do_op(3'd5, 8'd0, 1'b0);

        do_op(3'd4, 8'hA5, 1'b0);
        do_op(3'd6, 8'd0, 1'b0);
        do_op(3'd2, 8'd0, 1'b0);
        chk("lit_and_result", 32'(result), 32'hA5);
        chk("lit_and_depth", 32'(depth), 32'd1);
        do_op(3'd3, 8'd0, 1'b0);
        do_op(3'd5, 8'd0, 1'b0);
        chk("lit_pop_result", 32'(result), 32'h5A);
        chk("lit_pop_depth", 32'(depth), 32'd0);

        do_op(3'd4, 8'd7, 1'b0);
        do_op(3'd0, 8'd0, 1'b0);
        chk("lit_underflow_err", 32'(err), 32'd1);
        chk("lit_underflow_depth", 32'(depth), 32'd1);
        do_op(3'd4, 8'd1, 1'b0);
        chk("lit_err_cleared", 32'(err), 32'd0);
        do_op(3'd5, 8'd0, 1'b0);
        do_op(3'd5, 8'd0, 1'b0);

        for (int i = 0; i < 32; i++) do_op(3'd4, 8'($urandom), 1'b0);
        chk("lit_full_depth", 32'(depth), 32'd32);
        do_op(3'd4, 8'd9, 1'b0);
        chk("lit_overflow_pushi_err", 32'(err), 32'd1);
        do_op(3'd6, 8'd0, 1'b0);
        chk("lit_overflow_dup_err", 32'(err), 32'd1);
        do_op(3'd7, 8'd0, 1'b0);
        chk("lit_illegal_err", 32'(err), 32'd1);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = 3'd4;
            do_op(op, 8'($urandom), $urandom_range(0, 3) == 0);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_op(3'd4, 8'd1, 1'b0);
        do_op(3'd4, 8'd2, 1'b0);
        start = 1'b1; opcode = 3'd0;
        @(posedge clk);
        in_op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        p0 = push_cnt;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_strobes", 32'({stk_push, stk_pop, stk_tos}), 32'd0);
        in_op = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        chk("abort_no_push", 32'(push_cnt - p0), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        do_op(3'd4, 8'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
